// File: rtl/imu_pkg.sv
// Shared constants, state type and byte-to-axis helper for the IMU read scheduler.
package imu_pkg;

    localparam logic [7:0] ACCEL_BASE_DEFAULT = 8'h3B;
    localparam logic [7:0] GYRO_BASE_DEFAULT  = 8'h43;

    localparam int NUM_BYTES = 12;
    localparam int NUM_AXES  = 6;

    localparam int AXIS_AX = 0;
    localparam int AXIS_AY = 1;
    localparam int AXIS_AZ = 2;
    localparam int AXIS_GX = 3;
    localparam int AXIS_GY = 4;
    localparam int AXIS_GZ = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_PUBLISH,
        ST_ABORT
    } sched_state_e;

    // Top 10 bits of the big-endian 16-bit word; truncation keeps the sign bit on top.
    function automatic logic [9:0] axisValue(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo[7:6]};
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running period counter; tick_o is high on the wrap cycle (count == SAMPLE_PERIOD-1).
module sample_tick_gen #(
    parameter int unsigned SAMPLE_PERIOD = 500000
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic tick_o
);

    localparam logic [23:0] LAST_COUNT = 24'(SAMPLE_PERIOD - 1);

    logic [23:0] count_q;
    logic [23:0] count_d;

    assign tick_o  = (count_q == LAST_COUNT);
    assign count_d = tick_o ? 24'd0 : count_q + 24'd1;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= 24'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/imu_read_scheduler.sv
// Periodic 12-byte IMU burst reader that publishes six 10-bit axis values atomically.
// Optional response watchdog in WAIT is built when IMU_SCHED_WATCHDOG_EN is defined.
module imu_read_scheduler
    import imu_pkg::*;
#(
    parameter int unsigned SAMPLE_PERIOD = 500000,
    parameter logic [7:0]  ACCEL_BASE    = ACCEL_BASE_DEFAULT,
    parameter logic [7:0]  GYRO_BASE     = GYRO_BASE_DEFAULT,
    parameter int unsigned TIMEOUT       = 50000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       Enable,
    output logic       ReqValid,
    output logic [7:0] ReqAddr,
    input  logic       ReqReady,
    input  logic       RspValid,
    input  logic [7:0] RspData,
    input  logic       RspErr,
    output logic [9:0] AccelX,
    output logic [9:0] AccelY,
    output logic [9:0] AccelZ,
    output logic [9:0] GyroX,
    output logic [9:0] GyroY,
    output logic [9:0] GyroZ,
    output logic       DataValid,
    output logic       FrameErr,
    output logic [7:0] Overruns
);

    sched_state_e state_q, state_d;
    logic [3:0]   index_q, index_d;
    logic         pending_q, pending_d;
    logic [7:0]   overruns_q, overruns_d;
    logic [7:0]   shadow_q   [NUM_BYTES];
    logic [7:0]   frameBytes [NUM_BYTES];
    logic [9:0]   axis_q     [NUM_AXES];
    logic [9:0]   axis_d     [NUM_AXES];
    logic         shadowWe;
    logic         tick;
    logic         wdExpired;
    logic [7:0]   reqAddr;

    sample_tick_gen #(
        .SAMPLE_PERIOD(SAMPLE_PERIOD)
    ) u_tick (
        .clk_i  (CLOCK_50),
        .reset_i(reset),
        .tick_o (tick)
    );

`ifdef IMU_SCHED_WATCHDOG_EN
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] wdCount_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset || state_q != ST_WAIT) begin
            wdCount_q <= '0;
        end else begin
            wdCount_q <= wdCount_q + WD_W'(1);
        end
    end

    assign wdExpired = (wdCount_q == WD_LAST);
`else
    logic unusedTimeout;
    assign unusedTimeout = |TIMEOUT;
    assign wdExpired     = 1'b0;
`endif

    assign reqAddr = (index_q < 4'd6) ? ACCEL_BASE + {4'd0, index_q}
                                      : GYRO_BASE + {4'd0, index_q} - 8'd6;

    // The final byte bypasses the shadow so all axes load on the cycle it arrives.
    always_comb begin
        for (int i = 0; i < NUM_BYTES; i++) begin
            frameBytes[i] = shadow_q[i];
        end
        frameBytes[NUM_BYTES-1] = RspData;
    end

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        pending_d  = pending_q;
        overruns_d = overruns_q;
        axis_d     = axis_q;
        shadowWe   = 1'b0;
        ReqValid   = 1'b0;
        ReqAddr    = 8'd0;
        DataValid  = 1'b0;
        FrameErr   = 1'b0;

        if (tick && state_q != ST_IDLE) begin
            pending_d = 1'b1;
            if (overruns_q != 8'hFF) begin
                overruns_d = overruns_q + 8'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if ((tick || pending_q) && Enable) begin
                    state_d   = ST_REQ;
                    pending_d = 1'b0;
                    index_d   = 4'd0;
                end
            end
            ST_REQ: begin
                ReqValid = 1'b1;
                ReqAddr  = reqAddr;
                if (ReqReady) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (RspValid) begin
                    if (RspErr) begin
                        state_d = ST_ABORT;
                    end else begin
                        shadowWe = 1'b1;
                        if (index_q == 4'(NUM_BYTES - 1)) begin
                            state_d = ST_PUBLISH;
                            for (int a = 0; a < NUM_AXES; a++) begin
                                axis_d[a] = axisValue(frameBytes[2*a], frameBytes[2*a+1]);
                            end
                        end else begin
                            index_d = index_q + 4'd1;
                            state_d = ST_REQ;
                        end
                    end
                end else if (wdExpired) begin
                    state_d = ST_ABORT;
                end
            end
            ST_PUBLISH: begin
                DataValid = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_ABORT: begin
                FrameErr = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            index_q    <= 4'd0;
            pending_q  <= 1'b0;
            overruns_q <= 8'd0;
            axis_q     <= '{default: '0};
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            pending_q  <= pending_d;
            overruns_q <= overruns_d;
            axis_q     <= axis_d;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (shadowWe) begin
            shadow_q[index_q] <= RspData;
        end
    end

    assign AccelX   = axis_q[AXIS_AX];
    assign AccelY   = axis_q[AXIS_AY];
    assign AccelZ   = axis_q[AXIS_AZ];
    assign GyroX    = axis_q[AXIS_GX];
    assign GyroY    = axis_q[AXIS_GY];
    assign GyroZ    = axis_q[AXIS_GZ];
    assign Overruns = overruns_q;

endmodule
